int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_if.sv | 21 ++
 rtl/int_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/int_ctrl_if.sv
// CPU-side bus of the interrupt controller: IO register access plus request/acknowledge.
interface int_ctrl_if;
  logic        io_wr;
  logic        io_rd;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        int_rqst;
  logic [2:0]  int_vec;
  logic        int_ack;

  modport master (
    output io_wr, io_rd, io_addr, io_wdata, int_ack,
    input  io_rdata, int_rqst, int_vec
  );

  modport slave (
    input  io_wr, io_rd, io_addr, io_wdata, int_ack,
    output io_rdata, int_rqst, int_vec
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: 8-source edge-triggered priority interrupt controller (mask/pending/in-service/EOI).
// Define INT_CTRL_NEST_EN to allow a higher-priority source to interrupt one already in service.
module int_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'd50
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic [7:0] src,
  int_ctrl_if.slave  bus
);

  localparam int unsigned NSRC = 8;
  localparam int unsigned IDXW = 3;
  localparam logic [15:0] ADDR_MASK = BASE_ADDR;
  localparam logic [15:0] ADDR_PEND = 16'(BASE_ADDR + 16'd1);
  localparam logic [15:0] ADDR_ISV  = 16'(BASE_ADDR + 16'd2);
  localparam logic [15:0] ADDR_EOI  = 16'(BASE_ADDR + 16'd3);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] in_service;
  logic            int_rqst_q;
  logic [IDXW-1:0] int_vec_q;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] io_clr;
  logic [NSRC-1:0] ack_bit;
  logic [NSRC-1:0] eoi_bit;
  logic [NSRC-1:0] pending_n;
  logic [NSRC-1:0] in_service_n;
  logic [IDXW-1:0] win;
  logic            elig;
  logic            ack_ok;
  logic            wr_mask;
  logic            wr_pend;
  logic            wr_eoi;
  logic            unused_bits;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic logic [IDXW-1:0] hi_idx(input logic [NSRC-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (v[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  assign unused_bits = ^{bus.io_rd, bus.io_wdata[15:8]};

  always_comb begin
    rise    = src & ~src_q;
    cand    = pending & mask;
    win     = hi_idx(cand);
    ack_ok  = bus.int_ack & int_rqst_q;
    wr_mask = bus.io_wr && (bus.io_addr == ADDR_MASK);
    wr_pend = bus.io_wr && (bus.io_addr == ADDR_PEND);
    wr_eoi  = bus.io_wr && (bus.io_addr == ADDR_EOI);
    io_clr  = wr_pend ? bus.io_wdata[NSRC-1:0] : '0;
    ack_bit = ack_ok ? (NSRC'(1) << int_vec_q) : '0;
    eoi_bit = (wr_eoi && (in_service != '0)) ? (NSRC'(1) << hi_idx(in_service)) : '0;
    // A new edge outranks both the IO clear and the acknowledge clear.
    pending_n    = (pending & ~(io_clr | ack_bit)) | rise;
    in_service_n = (in_service & ~eoi_bit) | ack_bit;
`ifdef INT_CTRL_NEST_EN
    elig = (cand != '0) && ((in_service == '0) || (win > hi_idx(in_service)));
`else
    elig = (cand != '0) && (in_service == '0);
`endif
  end

  // Register read mux; unmatched addresses read as zero.
  always_comb begin
    bus.io_rdata = '0;
    if (bus.io_addr == ADDR_MASK)      bus.io_rdata = {8'd0, mask};
    else if (bus.io_addr == ADDR_PEND) bus.io_rdata = {8'd0, pending};
    else if (bus.io_addr == ADDR_ISV)  bus.io_rdata = {8'd0, in_service};
  end

  assign bus.int_rqst = int_rqst_q;
  assign bus.int_vec  = int_vec_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      src_q      <= '0;
      mask       <= '0;
      pending    <= '0;
      in_service <= '0;
      int_rqst_q <= 1'b0;
      int_vec_q  <= '0;
    end else begin
      src_q      <= src;
      pending    <= pending_n;
      in_service <= in_service_n;
      if (wr_mask) mask <= bus.io_wdata[NSRC-1:0];
      // An accepted acknowledge drops the request for one cycle while pending/in-service settle.
      int_rqst_q <= elig && !ack_ok;
      if (elig && !ack_ok) int_vec_q <= win;
    end
  end

endmodule
